// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline latch and a one-entry skid buffer.
// Define FETCH_PERF_CNT_EN to add the fetchCount/stallCount performance counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        PCSrc,
   input  logic [31:0] branchTarget,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pcOut,
   output logic [31:0] instruction,
   output logic        instrValid,
   output logic [31:0] ifPc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetchCount,
   output logic [31:0] stallCount
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        redir_pending_q, redir_pending_d;
   logic [31:0] redir_target_q, redir_target_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;

   logic        deliver;
   logic [31:0] deliver_pc;
   logic [31:0] deliver_instr;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d         = state_q;
      pc_d            = pc_q;
      redir_pending_d = redir_pending_q;
      redir_target_d  = redir_target_q;
      skid_pc_d       = skid_pc_q;
      skid_instr_d    = skid_instr_q;
      if_pc_d         = if_pc_q;
      if_instr_d      = if_instr_q;
      if_valid_d      = if_valid_q;
      deliver         = 1'b0;
      deliver_pc      = pc_plus4;
      deliver_instr   = imem_rdata;

      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            if (PCSrc) pc_d = branchTarget;
         end
         S_REQ: begin
            if (imem_ready) begin
               // A response for a redirected stream is stale: drop it and refetch.
               if (PCSrc || redir_pending_q) begin
                  pc_d            = PCSrc ? branchTarget : redir_target_q;
                  redir_pending_d = 1'b0;
               end else if (!stall) begin
                  deliver = 1'b1;
                  pc_d    = pc_plus4;
               end else begin
                  skid_pc_d    = pc_plus4;
                  skid_instr_d = imem_rdata;
                  pc_d         = pc_plus4;
                  state_d      = S_HOLD;
               end
            end else if (PCSrc) begin
               redir_pending_d = 1'b1;
               redir_target_d  = branchTarget;
            end
         end
         S_HOLD: begin
            if (PCSrc) begin
               pc_d    = branchTarget;
               state_d = S_REQ;
            end else if (!stall) begin
               deliver       = 1'b1;
               deliver_pc    = skid_pc_q;
               deliver_instr = skid_instr_q;
               state_d       = S_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush keeps pcOut; a bubble or flush always presents a nop.
      if (PCSrc) begin
         if_valid_d = 1'b0;
         if_instr_d = 32'h0;
      end else if (!stall) begin
         if (deliver) begin
            if_pc_d    = deliver_pc;
            if_instr_d = deliver_instr;
            if_valid_d = 1'b1;
         end else begin
            if_valid_d = 1'b0;
            if_instr_d = 32'h0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         pc_q            <= RESET_PC;
         redir_pending_q <= 1'b0;
         redir_target_q  <= 32'h0;
         skid_pc_q       <= 32'h0;
         skid_instr_q    <= 32'h0;
         if_pc_q         <= 32'h0;
         if_instr_q      <= 32'h0;
         if_valid_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         redir_pending_q <= redir_pending_d;
         redir_target_q  <= redir_target_d;
         skid_pc_q       <= skid_pc_d;
         skid_instr_q    <= skid_instr_d;
         if_pc_q         <= if_pc_d;
         if_instr_q      <= if_instr_d;
         if_valid_q      <= if_valid_d;
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = pc_q;
   assign ifPc        = pc_q;
   assign pcOut       = if_pc_q;
   assign instruction = if_instr_q;
   assign instrValid  = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (deliver)                fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall && if_valid_q)    stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetchCount = fetch_cnt_q;
   assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations,
// then randomized stall/redirect/wait/reset traffic checked every cycle against a reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        PCSrc;
   logic [31:0] branchTarget;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pcOut;
   logic [31:0] instruction;
   logic        instrValid;
   logic [31:0] ifPc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetchCount;
   logic [31:0] stallCount;
`endif

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .PCSrc        (PCSrc),
      .branchTarget (branchTarget),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .pcOut        (pcOut),
      .instruction  (instruction),
      .instrValid   (instrValid),
      .ifPc         (ifPc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetchCount   (fetchCount),
      .stallCount   (stallCount)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction memory contents as a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
   endfunction

   // Reference model: a fetch pointer, an optional parked response, and a list of
   // redirect targets seen while waiting (the newest one is the one honoured).
   bit          m_known = 1'b0;
   logic        m_started;
   logic [31:0] m_fpc;
   logic [63:0] m_parked[$];
   logic [31:0] m_redirs[$];
   logic [31:0] m_if_pc, m_if_ins;
   logic        m_if_v;
   logic [31:0] m_fcnt, m_scnt;

   task automatic model_edge();
      logic        have_new;
      logic [63:0] nw;
      have_new = 1'b0;
      nw       = 64'h0;
      if (reset) begin
         m_known   = 1'b1;
         m_started = 1'b0;
         m_fpc     = 32'h0;
         m_parked.delete();
         m_redirs.delete();
         m_if_pc   = 32'h0;
         m_if_ins  = 32'h0;
         m_if_v    = 1'b0;
         m_fcnt    = 32'h0;
         m_scnt    = 32'h0;
         return;
      end
      if (stall && m_if_v) m_scnt = m_scnt + 32'd1;
      if (!m_started) begin
         m_started = 1'b1;
         if (PCSrc) m_fpc = branchTarget;
      end else if (m_parked.size() != 0) begin
         if (PCSrc) begin
            m_parked.delete();
            m_fpc = branchTarget;
         end else if (!stall) begin
            nw = m_parked.pop_front();
            have_new = 1'b1;
         end
      end else if (imem_ready) begin
         if (PCSrc || m_redirs.size() != 0) begin
            m_fpc = PCSrc ? branchTarget : m_redirs[$];
            m_redirs.delete();
         end else begin
            if (stall) m_parked.push_back({m_fpc + 32'd4, imem_rdata});
            else begin
               nw = {m_fpc + 32'd4, imem_rdata};
               have_new = 1'b1;
            end
            m_fpc = m_fpc + 32'd4;
         end
      end else if (PCSrc) begin
         m_redirs.push_back(branchTarget);
      end
      if (PCSrc) begin
         m_if_v   = 1'b0;
         m_if_ins = 32'h0;
      end else if (!stall) begin
         if (have_new) begin
            m_if_pc  = nw[63:32];
            m_if_ins = nw[31:0];
            m_if_v   = 1'b1;
            m_fcnt   = m_fcnt + 32'd1;
         end else begin
            m_if_v   = 1'b0;
            m_if_ins = 32'h0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (m_known) begin
         check("imem_req",    {31'b0, imem_req},   {31'b0, (m_started && m_parked.size() == 0)});
         check("imem_addr",   imem_addr,           m_fpc);
         check("ifPc",        ifPc,                m_fpc);
         check("pcOut",       pcOut,               m_if_pc);
         check("instruction", instruction,         m_if_ins);
         check("instrValid",  {31'b0, instrValid}, {31'b0, m_if_v});
`ifdef FETCH_PERF_CNT_EN
         check("fetchCount",  fetchCount,          m_fcnt);
         check("stallCount",  stallCount,          m_scnt);
`endif
      end
   end

   // Apply inputs for one edge, let the model take the same edge, return at the next negedge.
   task automatic step(input logic rst, input logic st, input logic br,
                       input logic [31:0] tgt, input logic rdy);
      reset        = rst;
      stall        = st;
      PCSrc        = br;
      branchTarget = tgt;
      imem_ready   = rdy;
      imem_rdata   = mem_word(imem_addr);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".pcOut"},       pcOut,               32'h0);
      check({tag, ".instruction"}, instruction,         32'h0);
      check({tag, ".instrValid"},  {31'b0, instrValid}, 32'h0);
      check({tag, ".imem_req"},    {31'b0, imem_req},   32'h0);
      check({tag, ".imem_addr"},   imem_addr,           32'h0);
      check({tag, ".ifPc"},        ifPc,                32'h0);
   endtask

   initial begin
      logic [31:0] t;
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      check_reset_vals("por");

      // Zero-wait streaming after release.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("rel.imem_req", {31'b0, imem_req}, 32'h1);
      check("rel.valid", {31'b0, instrValid}, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s1.valid", {31'b0, instrValid}, 32'h1);
      check("s1.pcOut", pcOut, 32'h4);
      check("s1.instr", instruction, mem_word(32'h0));
      check("s1.addr", imem_addr, 32'h4);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s2.pcOut", pcOut, 32'h8);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("s3.pcOut", pcOut, 32'hC);
      check("s3.instr", instruction, mem_word(32'h8));

      // Stall for three cycles while a response arrives.
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check("st.req", {31'b0, imem_req}, 32'h0);
      check("st.pcOut", pcOut, 32'hC);
      check("st.addr", imem_addr, 32'h10);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      check("st3.instr", instruction, mem_word(32'h8));
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("skid.pcOut", pcOut, 32'h10);
      check("skid.instr", instruction, mem_word(32'hC));
      check("skid.req", {31'b0, imem_req}, 32'h1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("post.pcOut", pcOut, 32'h14);
      check("post.instr", instruction, mem_word(32'h10));

      // Taken branch while ready.
      step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1);
      check("br.valid", {31'b0, instrValid}, 32'h0);
      check("br.instr", instruction, 32'h0);
      check("br.pcOut", pcOut, 32'h14);
      check("br.addr", imem_addr, 32'h40);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("br2.pcOut", pcOut, 32'h44);
      check("br2.instr", instruction, mem_word(32'h40));

      // Two redirects during a wait at 0x10: the later target wins.
      step(1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
      step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
      step(1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      check("wait.addr", imem_addr, 32'h10);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("redir.addr", imem_addr, 32'h80);
      check("redir.valid", {31'b0, instrValid}, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("redir.pcOut", pcOut, 32'h84);
      check("redir.instr", instruction, mem_word(32'h80));

      // Reset mid-wait, then reset while holding a skid word.
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      check_reset_vals("rst_wait");
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("rr.pcOut", pcOut, 32'h4);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      check("rr.hold_req", {31'b0, imem_req}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      check_reset_vals("rst_hold");
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

      // PC+4 wraps at the top of the address space.
      step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
      check("wrap.addr", imem_addr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      check("wrap.pcOut", pcOut, 32'h0);
      check("wrap.instr", instruction, mem_word(32'hFFFF_FFFC));
      check("wrap.addr2", imem_addr, 32'h0);

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hC);
         else                           t = $urandom & 32'h0000_0FFF;
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 11) == 0, t, $urandom_range(0, 9) < 6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
